// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan-out engine.
//   - default 640x480 timing constants (pixel clocks / lines)
//   - vga_timing_t: one axis of raster timing (active, fp, sync, bp)
//   - in_sync(): true when a counter position lies inside the sync pulse
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  // The sync pulse starts right after the front porch, which follows active video.
  function automatic logic in_sync(input int pos, input int active, input int fp, input int sync);
    return (pos >= active + fp) && (pos < active + fp + sync);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register used to carry per-pixel
// control bits alongside the source's fixed read latency.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  synchronous active-low reset, loads every stage with RESET_VAL
//   i_data   value entering the pipe
//   o_data   value that entered DEPTH edges earlier
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Reset loads the idle value so the delayed sync lines sit at their
  // inactive level while the pipe refills.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator and pixel scan-out.
// Requests pixel (pix_x, pix_y) from an external source, expects the colour
// SRC_LAT cycles later, and registers it onto the pins together with sync,
// data-enable and frame_start delayed by the same amount.
// Ports:
//   clk, rst_n                 pixel clock, synchronous active-low reset
//   pix_req, pix_x, pix_y      registered pixel request to the source
//   pix_data, pix_valid        {r,g,b} and its valid flag in the return slot
//   pat_en                     select internal colour bars
//   clear_underflow            clears the sticky underflow flag
//   hsync, vsync, r, g, b, de  VGA pin outputs
//   frame_start                one-cycle pulse with output pixel (0,0)
//   underflow                  sticky: source missed a requested pixel
// Optional feature: define VGA_SCANOUT_PATTERN_EN to build the colour-bar
// generator; without it pat_en is ignored.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CW        = 4,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int SRC_LAT   = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            pix_req,
  output logic [XW-1:0]   pix_x,
  output logic [YW-1:0]   pix_y,
  input  logic [3*CW-1:0] pix_data,
  input  logic            pix_valid,
  input  logic            pat_en,
  input  logic            clear_underflow,
  output logic            hsync,
  output logic            vsync,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            de,
  output logic            frame_start,
  output logic            underflow
);

  localparam vga_timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  // {req, hs, vs, frame0} with both syncs at their inactive level
  localparam logic [3:0]  PIPE_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL, 1'b0};

  logic [XW-1:0]   r_h;
  logic [YW-1:0]   r_v;
  logic            r_req, r_hs, r_vs, r_f0;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            w_hLast, w_vLast, w_active, w_hs, w_vs, w_f0;
  logic [3:0]      w_pipe;
  logic            w_dReq, w_dHs, w_dVs, w_dF0;
  logic [3*CW-1:0] w_rgbNext;
  logic            w_ufSet;
  logic            r_hsOut, r_vsOut, r_de, r_fs, r_uf;
  logic [CW-1:0]   r_r, r_g, r_b;

  assign w_hLast  = (r_h == XW'(H_TOTAL - 1));
  assign w_vLast  = (r_v == YW'(V_TOTAL - 1));
  assign w_active = (int'(r_h) < H_TIM.active) && (int'(r_v) < V_TIM.active);
  assign w_hs     = in_sync(int'(r_h), H_TIM.active, H_TIM.fp, H_TIM.sync) ? HSYNC_POL : ~HSYNC_POL;
  assign w_vs     = in_sync(int'(r_v), V_TIM.active, V_TIM.fp, V_TIM.sync) ? VSYNC_POL : ~VSYNC_POL;
  assign w_f0     = (r_h == '0) && (r_v == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_hLast) begin
      r_h <= '0;
      r_v <= w_vLast ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Request stage: everything about the raster position is decided here, and
  // the delay line replays it when the source's answer arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_f0  <= 1'b0;
    end else begin
      r_req <= w_active;
      r_x   <= r_h;
      r_y   <= r_v;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_f0  <= w_f0;
    end
  end

  vga_delay_line #(.WIDTH(4), .DEPTH(SRC_LAT), .RESET_VAL(PIPE_IDLE)) u_ctrlPipe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  ({r_req, r_hs, r_vs, r_f0}),
    .o_data  (w_pipe)
  );

  assign {w_dReq, w_dHs, w_dVs, w_dF0} = w_pipe;

`ifdef VGA_SCANOUT_PATTERN_EN
  logic [XW+2:0] w_hx8;
  logic [2:0]    w_barIdx;
  logic          r_pat;
  logic [2:0]    r_bar;
  logic [3:0]    w_patPipe;
  logic          w_patMode;
  logic [2:0]    w_bar;

  // Bar index (x*8)/H_ACTIVE; only meaningful inside active video.
  assign w_hx8    = {r_h, 3'b000};
  assign w_barIdx = 3'(w_hx8 / (XW+3)'(H_ACTIVE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat <= 1'b0;
      r_bar <= '0;
    end else begin
      r_pat <= pat_en;
      r_bar <= w_barIdx;
    end
  end

  vga_delay_line #(.WIDTH(4), .DEPTH(SRC_LAT), .RESET_VAL(4'b0)) u_patPipe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  ({r_pat, r_bar}),
    .o_data  (w_patPipe)
  );

  assign {w_patMode, w_bar} = w_patPipe;
`else
  logic w_unusedPatEn;
  assign w_unusedPatEn = pat_en;
`endif

  // Colour is only taken in a request slot; a missing pixel blanks to zero
  // and raises underflow. Bars override the source entirely.
  always_comb begin
    w_rgbNext = '0;
    w_ufSet   = 1'b0;
    if (w_dReq) begin
      if (pix_valid) w_rgbNext = pix_data;
      else           w_ufSet   = 1'b1;
`ifdef VGA_SCANOUT_PATTERN_EN
      if (w_patMode) begin
        w_rgbNext = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
        w_ufSet   = 1'b0;
      end
`endif
    end
  end

  // A new underflow takes priority over a concurrent clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsOut <= ~HSYNC_POL;
      r_vsOut <= ~VSYNC_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_hsOut <= w_dHs;
      r_vsOut <= w_dVs;
      r_de    <= w_dReq;
      r_fs    <= w_dF0;
      r_r     <= w_rgbNext[3*CW-1:2*CW];
      r_g     <= w_rgbNext[2*CW-1:CW];
      r_b     <= w_rgbNext[CW-1:0];
      if (w_ufSet)              r_uf <= 1'b1;
      else if (clear_underflow) r_uf <= 1'b0;
    end
  end

  assign pix_req     = r_req;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign hsync       = r_hsOut;
  assign vsync       = r_vsOut;
  assign de          = r_de;
  assign frame_start = r_fs;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: small-raster bench for vga_scanout. Two instances share
// the stimulus: A (SRC_LAT 3, active-low syncs) and B (SRC_LAT 1, active-high
// syncs). A raster-arithmetic model predicts every output after every edge.
module tb_vga_scanout;

  localparam int CW = 4;
  localparam int DW = 3 * CW;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
`ifdef VGA_SCANOUT_PATTERN_EN
  localparam bit PAT_BUILD = 1'b1;
`else
  localparam bit PAT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic pix_valid = 1'b1, pat_en = 1'b0, clear_underflow = 1'b0;

  logic reqA, hsA, vsA, deA, fsA, ufA;
  logic [XW-1:0] xA;
  logic [YW-1:0] yA;
  logic [CW-1:0] rA, gA, bA;
  logic reqB, hsB, vsB, deB, fsB, ufB;
  logic [XW-1:0] xB;
  logic [YW-1:0] yB;
  logic [CW-1:0] rB, gB, bB;

  int assertCount = 0;
  int failCount = 0;
  int n = 0;
  bit ufMdlA = 1'b0, ufMdlB = 1'b0;
  logic [DW-1:0] dataHist [4096];
  logic validHist [4096];
  logic clrHist [4096];
  logic patHist [4096];

  always #5 clk = ~clk;

  vga_scanout #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SRC_LAT(LAT_A)) dutA (
    .clk(clk), .rst_n(rst_n), .pix_req(reqA), .pix_x(xA), .pix_y(yA),
    .pix_data(pix_data), .pix_valid(pix_valid), .pat_en(pat_en),
    .clear_underflow(clear_underflow), .hsync(hsA), .vsync(vsA),
    .r(rA), .g(gA), .b(bA), .de(deA), .frame_start(fsA), .underflow(ufA));

  vga_scanout #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SRC_LAT(LAT_B)) dutB (
    .clk(clk), .rst_n(rst_n), .pix_req(reqB), .pix_x(xB), .pix_y(yB),
    .pix_data(pix_data), .pix_valid(pix_valid), .pat_en(pat_en),
    .clear_underflow(clear_underflow), .hsync(hsB), .vsync(vsB),
    .r(rB), .g(gB), .b(bB), .de(deB), .frame_start(fsB), .underflow(ufB));

  // Model: after edge nn (release edge is nn=1) the pins show raster
  // position nn-lat-2 and the request registers show position nn-1.
  function automatic int hi(int i);
    return i & 4095;
  endfunction

  function automatic int posAt(int nn, int lat);
    if (nn < lat + 2) return -1;
    return (nn - lat - 2) % FRAME;
  endfunction

  function automatic bit isActive(int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit hsyncOn(int p);
    int x = p % HT;
    return (x >= HA + HF) && (x < HA + HF + HS);
  endfunction

  function automatic bit vsyncOn(int p);
    int y = p / HT;
    return (y >= VA + VF) && (y < VA + VF + VS);
  endfunction

  function automatic bit patSlot(int nn, int lat);
    return PAT_BUILD && patHist[hi(nn - lat - 1)];
  endfunction

  function automatic logic [DW-1:0] expColour(int nn, int lat);
    int p = posAt(nn, lat);
    int idx;
    if (p < 0 || !isActive(p)) return '0;
    if (patSlot(nn, lat)) begin
      idx = ((p % HT) * 8) / HA;
      return {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
    end
    return validHist[hi(nn)] ? dataHist[hi(nn)] : '0;
  endfunction

  function automatic bit nextUf(bit uf, int nn, int lat);
    int p = posAt(nn, lat);
    if (p >= 0 && isActive(p) && !patSlot(nn, lat) && !validHist[hi(nn)]) return 1'b1;
    if (clrHist[hi(nn)]) return 1'b0;
    return uf;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic compareAll();
    int q, pA, pB;
    logic [DW-1:0] cA, cB;
    q  = (n >= 1) ? (n - 1) % FRAME : -1;
    pA = posAt(n, LAT_A);
    pB = posAt(n, LAT_B);
    cA = expColour(n, LAT_A);
    cB = expColour(n, LAT_B);
    checkOutput("reqA", reqA, q >= 0 && isActive(q));
    checkOutput("xA", xA, (q >= 0) ? q % HT : 0);
    checkOutput("yA", yA, (q >= 0) ? q / HT : 0);
    checkOutput("hsA", hsA, !(pA >= 0 && hsyncOn(pA)));
    checkOutput("vsA", vsA, !(pA >= 0 && vsyncOn(pA)));
    checkOutput("deA", deA, pA >= 0 && isActive(pA));
    checkOutput("fsA", fsA, pA == 0);
    checkOutput("rgbA", {rA, gA, bA}, cA);
    checkOutput("ufA", ufA, ufMdlA);
    checkOutput("reqB", reqB, q >= 0 && isActive(q));
    checkOutput("xB", xB, (q >= 0) ? q % HT : 0);
    checkOutput("yB", yB, (q >= 0) ? q / HT : 0);
    checkOutput("hsB", hsB, pB >= 0 && hsyncOn(pB));
    checkOutput("vsB", vsB, pB >= 0 && vsyncOn(pB));
    checkOutput("deB", deB, pB >= 0 && isActive(pB));
    checkOutput("fsB", fsB, pB == 0);
    checkOutput("rgbB", {rB, gB, bB}, cB);
    checkOutput("ufB", ufB, ufMdlB);
  endtask

  task automatic applyStimulus(input logic rstV, input logic validV, input logic clrV,
                               input logic patV, input logic [DW-1:0] dataV);
    rst_n = rstV;
    pix_valid = validV;
    clear_underflow = clrV;
    pat_en = patV;
    pix_data = dataV;
    @(posedge clk);
    #1;
    if (!rstV) begin
      n = 0;
      ufMdlA = 1'b0;
      ufMdlB = 1'b0;
    end else begin
      n++;
      dataHist[hi(n)] = dataV;
      validHist[hi(n)] = validV;
      clrHist[hi(n)] = clrV;
      patHist[hi(n)] = patV;
      ufMdlA = nextUf(ufMdlA, n, LAT_A);
      ufMdlB = nextUf(ufMdlB, n, LAT_B);
    end
    compareAll();
  endtask

  task automatic randomTick();
    applyStimulus(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  task automatic checkResetPins(input string tag);
    checkOutput({tag, "ReqA"}, reqA, 0);
    checkOutput({tag, "XYA"}, {xA, yA}, 0);
    checkOutput({tag, "HsA"}, hsA, 1);
    checkOutput({tag, "VsA"}, vsA, 1);
    checkOutput({tag, "RgbA"}, {rA, gA, bA}, 0);
    checkOutput({tag, "DeA"}, deA, 0);
    checkOutput({tag, "FsA"}, fsA, 0);
    checkOutput({tag, "UfA"}, ufA, 0);
    checkOutput({tag, "HsB"}, hsB, 0);
    checkOutput({tag, "VsB"}, vsB, 0);
  endtask

  initial begin
    int hsLow, vsLow, deHigh, fsCnt, hsHighB, vsHighB, deBefore;
    bit found;
    hsLow = 0; vsLow = 0; deHigh = 0; fsCnt = 0; hsHighB = 0; vsHighB = 0; deBefore = 0;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkResetPins("reset");

    // First frames: hand-computed pin timing for instance A.
    for (int i = 0; i < 100; i++) begin
      randomTick();
      case (n)
        1: begin
          checkOutput("firstReqA", reqA, 1);
          checkOutput("firstXYA", {xA, yA}, 0);
        end
        4:  checkOutput("fsBeforeFillA", fsA, 0);
        5:  checkOutput("firstFsA", fsA, 1);
        10: checkOutput("hsLowStartA", hsA, 0);
        12: checkOutput("hsBackPorchA", hsA, 1);
        37: checkOutput("vsLowStartA", vsA, 0);
        45: checkOutput("vsEndA", vsA, 1);
        53: checkOutput("secondFsA", fsA, 1);
        default: ;
      endcase
      if (n >= 53 && n <= 100) begin
        hsLow += (hsA == 1'b0);
        vsLow += (vsA == 1'b0);
        deHigh += deA;
        fsCnt += fsA;
        hsHighB += hsB;
        vsHighB += vsB;
      end
    end
    checkOutput("hsLowPerFrameA", hsLow, 12);
    checkOutput("vsLowPerFrameA", vsLow, 8);
    checkOutput("deHighPerFrameA", deHigh, 12);
    checkOutput("fsPerFrameA", fsCnt, 1);
    checkOutput("hsHighPerFrameB", hsHighB, 12);
    checkOutput("vsHighPerFrameB", vsHighB, 8);

    // Underflow: clear alone, set together with clear, stickiness.
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, DW'($urandom));
    checkOutput("ufClearAloneA", ufA, 0);
    found = 1'b0;
    for (int k = 0; k < FRAME && !found; k++) begin
      if (posAt(n + 1, LAT_A) >= 0 && isActive(posAt(n + 1, LAT_A))) found = 1'b1;
      else applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    end
    if (!found) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL ufSlotSearch: no active slot within %0d cycles", FRAME);
    end else begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom));
      checkOutput("ufSetWinsA", ufA, 1);
      checkOutput("ufBlankA", {rA, gA, bA}, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
      checkOutput("ufStickyA", ufA, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, DW'($urandom));
      checkOutput("ufClearedA", ufA, 0);
    end

    // Reset for one cycle in the middle of a line.
    for (int k = 0; k < HT && (((n - 1) % FRAME) % HT) != 2; k++) randomTick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
    checkResetPins("midReset");
    for (int i = 0; i < 60; i++) begin
      randomTick();
      if (n < 5) deBefore += deA;
      case (n)
        4:  checkOutput("fsAfterResetEarlyA", fsA, 0);
        5:  checkOutput("fsAfterResetA", fsA, 1);
        53: checkOutput("fsNextFrameA", fsA, 1);
        default: ;
      endcase
    end
    checkOutput("deBeforeFsA", deBefore, 0);

    repeat (150) randomTick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
